seq_divider16: RTL and testbench

//  Iterative unsigned divider for the stack processor datapath. It is the inverse
//  of the ALU add/subtract carry chain: one restoring shift-subtract step per clock.

---
 rtl/seq_divider16_if.sv | 46 ++++
 rtl/seq_divider16.sv | 165 ++++++++++++++++
 tb/tb_seq_divider16.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/seq_divider16_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divider16_if
//  Description : Start/busy/done handshake and operand/result bundle between
//                the stack-processor control unit (master) and the iterative
//                divider (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface seq_divider16_if #(
    parameter int WIDTH = 16
);
    // Request side, driven by the control unit
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;

    // Status and results, driven by the divider
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start,
        output dividend,
        output divisor,
        input  busy,
        input  done,
        input  quotient,
        input  remainder,
        input  div_by_zero
    );

    modport slave (
        input  start,
        input  dividend,
        input  divisor,
        output busy,
        output done,
        output quotient,
        output remainder,
        output div_by_zero
    );
endinterface
`default_nettype wire

// File: rtl/seq_divider16.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divider16
//  Description : Iterative unsigned restoring divider. One shift-subtract step
//                per clock, WIDTH steps per division. Results are held stable
//                for write-back until the next accepted start.
//  Revision    : 1.0  initial release
// ============================================================================
module seq_divider16 #(
    parameter int WIDTH = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    seq_divider16_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    // Count value seen during the final step; the step that sees it is step WIDTH.
    localparam logic [CNT_W-1:0] c_last_step = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Control strobes decoded from the state machine
    logic w_load_run;
    logic w_load_dbz;
    logic w_step;
    logic w_finish;
    logic w_busy;
    logic w_done;

    // Working registers. The partial remainder is always below the divisor,
    // so it fits WIDTH bits between steps; the extra bit only exists in the
    // shifted/trial values inside a step.
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic [CNT_W-1:0] r_cnt;

    // Held results
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_div_by_zero;

    // Step datapath
    logic [WIDTH:0]   w_rem_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_no_borrow;
    logic [WIDTH-1:0] w_rem_step;
    logic [WIDTH-1:0] w_q_step;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and control strobes
    always_comb begin
        w_state_nxt = r_state;
        w_load_run  = 1'b0;
        w_load_dbz  = 1'b0;
        w_step      = 1'b0;
        w_finish    = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;

        case (r_state)
            S_IDLE, S_DONE: begin
                w_done = (r_state == S_DONE);
                if (bus.start) begin
                    if (bus.divisor == '0) begin
                        // Zero divisor short-circuits straight to a result
                        w_load_dbz  = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_load_run  = 1'b1;
                        w_state_nxt = S_RUN;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end

            S_RUN: begin
                // start is deliberately ignored here
                w_busy = 1'b1;
                w_step = 1'b1;
                if (r_cnt == c_last_step) begin
                    w_finish    = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // One restoring step: shift {rem,q} left, try subtracting the divisor,
    // keep the difference and set the quotient bit only when no borrow occurs.
    always_comb begin
        w_rem_shift = {r_rem, r_q[WIDTH-1]};
        w_trial     = w_rem_shift - {1'b0, r_d};
        w_no_borrow = ~w_trial[WIDTH];
        w_rem_step  = w_no_borrow ? w_trial[WIDTH-1:0] : w_rem_shift[WIDTH-1:0];
        w_q_step    = {r_q[WIDTH-2:0], w_no_borrow};
    end

    // Working registers: capture operands on accepted start, step while running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem <= '0;
            r_q   <= '0;
            r_d   <= '0;
            r_cnt <= '0;
        end else if (w_load_run) begin
            r_rem <= '0;
            r_q   <= bus.dividend;
            r_d   <= bus.divisor;
            r_cnt <= '0;
        end else if (w_step) begin
            r_rem <= w_rem_step;
            r_q   <= w_q_step;
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Result registers: written only when entering DONE (flag cleared on a new run)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
        end else if (w_load_dbz) begin
            r_quotient    <= '1;
            r_remainder   <= bus.dividend;
            r_div_by_zero <= 1'b1;
        end else if (w_load_run) begin
            r_div_by_zero <= 1'b0;
        end else if (w_finish) begin
            r_quotient    <= w_q_step;
            r_remainder   <= w_rem_step;
        end
    end

    assign bus.busy        = w_busy;
    assign bus.done        = w_done;
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_div_by_zero;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider16.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_divider16
//  Description : Self-checking bench for seq_divider16. Expected results come
//                from plain integer division in the bench.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seq_divider16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_divider16_if #(.WIDTH(16)) bus ();

    seq_divider16 #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present operands with start for exactly one rising edge (E0), then
    // scramble the operand inputs to show they are not re-sampled.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b);
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.dividend = 16'($urandom);
        bus.divisor  = 16'($urandom);
    endtask

    // Called just after E0. Returns latency in edges counted from E0
    // inclusive (-1 on timeout) and how many cycles busy was seen high.
    task automatic wait_done(output int lat, output int busy_n);
        int edges;
        edges  = 0;
        busy_n = 0;
        lat    = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = edges + 1;
                break;
            end
            if (bus.busy) busy_n++;
            @(posedge clk);
            edges++;
        end
    endtask

    // Full operation against the arithmetic reference; ends on a negedge.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input string tag);
        logic [15:0] eq, er;
        logic        edbz;
        int          elat, ebusy, lat, bn;
        if (b == 16'd0) begin
            eq = 16'hFFFF; er = a; edbz = 1'b1; elat = 1; ebusy = 0;
        end else begin
            eq = a / b; er = a % b; edbz = 1'b0; elat = 17; ebusy = 16;
        end
        start_op(a, b);
        wait_done(lat, bn);
        check({tag, "_lat"},  lat,             elat);
        check({tag, "_busy"}, bn,              ebusy);
        check({tag, "_q"},    bus.quotient,    eq);
        check({tag, "_r"},    bus.remainder,   er);
        check({tag, "_dbz"},  bus.div_by_zero, edbz);
        check({tag, "_busy_at_done"}, bus.busy, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_done_1cyc"}, bus.done,     1'b0);
        check({tag, "_q_held"},    bus.quotient, eq);
    endtask

    initial begin
        int lat, bn;
        logic [15:0] a, b;
        int sel;

        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", bus.busy,        1'b0);
        check("rst_done", bus.done,        1'b0);
        check("rst_q",    bus.quotient,    16'd0);
        check("rst_r",    bus.remainder,   16'd0);
        check("rst_dbz",  bus.div_by_zero, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed operand patterns and boundaries
        do_op(16'd100,   16'd7,      "d100_7");
        do_op(16'hFFFF,  16'h0001,   "ffff_1");
        do_op(16'hFFFF,  16'hFFFF,   "ffff_ffff");
        do_op(16'd3,     16'd10,     "d3_10");
        do_op(16'd0,     16'd5,      "d0_5");
        do_op(16'd5,     16'd0,      "d5_0");

        // start during RUN is ignored
        start_op(16'd1000, 16'd9);
        repeat (5) @(posedge clk);
        @(negedge clk);
        bus.dividend = 16'd7;
        bus.divisor  = 16'd2;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        wait_done(lat, bn);
        check("ign_lat",  lat,             11);
        check("ign_busy", bn,              10);
        check("ign_q",    bus.quotient,    16'd111);
        check("ign_r",    bus.remainder,   16'd1);
        check("ign_dbz",  bus.div_by_zero, 1'b0);

        // Back-to-back start issued in the DONE cycle
        do_op(16'd7, 16'd2, "b2b");

        // Zero divide then a normal op clears the flag
        do_op(16'h1234, 16'd0, "dz2");
        do_op(16'h1234, 16'd3, "after_dz");

        // Asynchronous reset mid-run
        start_op(16'd200, 16'd3);
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", bus.busy,        1'b0);
        check("arst_done", bus.done,        1'b0);
        check("arst_q",    bus.quotient,    16'd0);
        check("arst_r",    bus.remainder,   16'd0);
        check("arst_dbz",  bus.div_by_zero, 1'b0);
        bn = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.done || bus.busy) bn++;
        end
        check("arst_quiet", bn, 0);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(16'd200, 16'd3, "rerun");

        // Randomized operand pairs
        for (int i = 0; i < 1500; i++) begin
            a   = 16'($urandom);
            sel = $urandom_range(0, 9);
            if (sel == 0)      b = 16'd0;
            else if (sel < 4)  b = 16'($urandom_range(1, 15));
            else if (sel == 4) b = a;
            else               b = 16'($urandom);
            do_op(a, b, "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
